// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter issuing one transaction at a time into a core chain.
// Optional response timeout: define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  input  logic                  req0_rw_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  output logic [DATA_WIDTH-1:0] req0_rdata_o,
  output logic                  req0_rvalid_o,
  output logic                  req0_err_o,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_wdata_i,
  input  logic                  req1_rw_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  output logic [DATA_WIDTH-1:0] req1_rdata_o,
  output logic                  req1_rvalid_o,
  output logic                  req1_err_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic                  bus_rw_o,
  output logic                  bus_valid_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_rw_i,
  input  logic                  bus_valid_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [1:0]            rvalid_q, rvalid_d;

  logic                  any_c;
  logic                  sel_c;
  logic                  tmo_c;
  logic                  done_c;
  logic [DATA_WIDTH-1:0] resp_data_c;
  logic                  unused_c;

  // On a tie the requester not granted last wins; a lone requester always wins.
  assign any_c       = req0_valid_i | req1_valid_i;
  assign sel_c       = (req0_valid_i & req1_valid_i) ? ~last_q : req1_valid_i;
  assign done_c      = (state_q == WAIT) & (bus_valid_i | tmo_c);
  assign resp_data_c = bus_valid_i ? bus_rdata_i : '1;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;

  // Wait counter restarts on every WAIT entry; a returning strobe beats the limit.
  always_comb begin
    cnt_d = '0;
    err_d = '0;
    tmo_c = 1'b0;
    if (state_q == WAIT && !bus_valid_i) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
        tmo_c        = 1'b1;
        err_d[gnt_q] = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign req0_err_o = err_q[0];
  assign req1_err_o = err_q[1];
  assign unused_c   = bus_rw_i;
`else
  assign tmo_c      = 1'b0;
  assign req0_err_o = 1'b0;
  assign req1_err_o = 1'b0;
  assign unused_c   = ^{bus_rw_i, 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rvalid_d = '0;
    case (state_q)
      IDLE: begin
        if (any_c) begin
          gnt_d   = sel_c;
          addr_d  = sel_c ? req1_addr_i  : req0_addr_i;
          wdata_d = sel_c ? req1_wdata_i : req0_wdata_i;
          rw_d    = sel_c ? req1_rw_i    : req0_rw_i;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done_c) begin
          rvalid_d[gnt_q] = 1'b1;
          if (gnt_q) rdata1_d = resp_data_c;
          else       rdata0_d = resp_data_c;
          state_d = RESP;
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset leaves req0 with tie priority by pretending req1 was granted last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Accept pulse is combinational so it lands in the same cycle as the grant decision.
  assign req0_ready_o  = ~rst & (state_q == IDLE) & any_c & ~sel_c;
  assign req1_ready_o  = ~rst & (state_q == IDLE) & any_c &  sel_c;
  assign req0_rdata_o  = rdata0_q;
  assign req1_rdata_o  = rdata1_q;
  assign req0_rvalid_o = rvalid_q[0];
  assign req1_rvalid_o = rvalid_q[1];
  assign bus_addr_o    = addr_q;
  assign bus_wdata_o   = wdata_q;
  assign bus_rw_o      = rw_q;
  assign bus_valid_o   = (state_q == ISSUE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed + randomized bench for bus_arbiter against a transaction-level round-robin model.
module tb_bus_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic [DW-1:0] req0_wdata_i, req1_wdata_i;
  logic          req0_rw_i, req1_rw_i, req0_valid_i, req1_valid_i;
  logic          req0_ready_o, req1_ready_o;
  logic [DW-1:0] req0_rdata_o, req1_rdata_o;
  logic          req0_rvalid_o, req1_rvalid_o, req0_err_o, req1_err_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic          bus_rw_o, bus_valid_o;
  logic [DW-1:0] bus_rdata_i;
  logic          bus_rw_i, bus_valid_i;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            last_gnt;
  logic [DW-1:0] exp_rdata [2];

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i), .req0_rw_i(req0_rw_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_rdata_o(req0_rdata_o),
    .req0_rvalid_o(req0_rvalid_o), .req0_err_o(req0_err_o),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i), .req1_rw_i(req1_rw_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_rdata_o(req1_rdata_o),
    .req1_rvalid_o(req1_rvalid_o), .req1_err_o(req1_err_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rw_o(bus_rw_o),
    .bus_valid_o(bus_valid_o), .bus_rdata_i(bus_rdata_i), .bus_rw_i(bus_rw_i),
    .bus_valid_i(bus_valid_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rvalid"}, {req0_rvalid_o, req1_rvalid_o}, 32'd0);
    chk({tag, "_bus_valid"}, bus_valid_o, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    bus_valid_i = 1'b0; bus_rdata_i = '0; bus_rw_i = 1'b0;
    tick();
    tick();
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    #1;
    chk("rst_ready", {req0_ready_o, req1_ready_o}, 32'd0);
    chk("rst_rdata", {req0_rdata_o, req1_rdata_o}, 32'd0);
    chk("rst_bus", {bus_addr_o, bus_wdata_o}, 32'd0);
    chk("rst_flags", {req0_rvalid_o, req1_rvalid_o, req0_err_o, req1_err_o, bus_rw_o, bus_valid_o}, 32'd0);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rst = 1'b0;
    last_gnt = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // One full transaction from the IDLE cycle in which requests are presented.
  task automatic run_txn(input int lat, input logic [DW-1:0] data, input bit stray, input bit drop);
    int            w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          erw;
    w   = (req0_valid_i && req1_valid_i) ? 1 - last_gnt : (req1_valid_i ? 1 : 0);
    ea  = (w == 1) ? req1_addr_i  : req0_addr_i;
    ew  = (w == 1) ? req1_wdata_i : req0_wdata_i;
    erw = (w == 1) ? req1_rw_i    : req0_rw_i;
    #1;
    chk("ready0", req0_ready_o, 32'(w == 0));
    chk("ready1", req1_ready_o, 32'(w == 1));
    chk("idle_bus_valid", bus_valid_o, 32'd0);
    tick();
    chk("issue_bus_valid", bus_valid_o, 32'd1);
    chk("issue_addr", bus_addr_o, 32'(ea));
    chk("issue_wdata", bus_wdata_o, 32'(ew));
    chk("issue_rw", bus_rw_o, 32'(erw));
    chk("issue_ready", {req0_ready_o, req1_ready_o}, 32'd0);
    if (drop) begin
      if (w == 0) req0_valid_i = 1'b0;
      else        req1_valid_i = 1'b0;
    end
    if (stray) begin
      bus_valid_i = 1'b1;
      bus_rdata_i = DW'($urandom);
    end
    tick();
    bus_valid_i = 1'b0;
    for (int i = 0; i < lat; i++) begin
      chk_quiet("wait");
      chk("wait_ready", {req0_ready_o, req1_ready_o}, 32'd0);
      tick();
    end
    bus_valid_i = 1'b1;
    bus_rdata_i = data;
    tick();
    bus_valid_i = stray;
    bus_rdata_i = ~data;
    exp_rdata[w] = data;
    chk("resp_rvalid0", req0_rvalid_o, 32'(w == 0));
    chk("resp_rvalid1", req1_rvalid_o, 32'(w == 1));
    chk("resp_rdata0", req0_rdata_o, 32'(exp_rdata[0]));
    chk("resp_rdata1", req1_rdata_o, 32'(exp_rdata[1]));
    chk("resp_err", {req0_err_o, req1_err_o}, 32'd0);
    last_gnt = w;
    tick();
    bus_valid_i = 1'b0;
    chk("post_rvalid", {req0_rvalid_o, req1_rvalid_o}, 32'd0);
  endtask

  initial begin
    req0_addr_i = '0; req0_wdata_i = '0; req0_rw_i = 1'b0;
    req1_addr_i = '0; req1_wdata_i = '0; req1_rw_i = 1'b0;
    do_reset();

    // Continuous contention after reset alternates starting with req0.
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_addr_i = AW'($urandom); req0_wdata_i = DW'($urandom); req0_rw_i = 1'($urandom);
      req1_addr_i = AW'($urandom); req1_wdata_i = DW'($urandom); req1_rw_i = 1'($urandom);
      run_txn(0, DW'($urandom), 1'b0, 1'b0);
    end

    // Single read from req0.
    req0_valid_i = 1'b1; req1_valid_i = 1'b0;
    req0_addr_i = 16'h0005; req0_rw_i = 1'b0; req0_wdata_i = 16'h0000;
    run_txn(2, 16'h1234, 1'b0, 1'b1);

    // Write from req1; req0 outputs must hold.
    req0_valid_i = 1'b0; req1_valid_i = 1'b1;
    req1_addr_i = 16'h0006; req1_wdata_i = 16'h00FF; req1_rw_i = 1'b1;
    run_txn(1, 16'hBEEF, 1'b0, 1'b1);

    // Stray return strobes while idle.
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    bus_valid_i = 1'b1; bus_rdata_i = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("stray_idle");
      chk("stray_rdata", {req0_rdata_o, req1_rdata_o}, {exp_rdata[0], exp_rdata[1]});
    end
    bus_valid_i = 1'b0;
    tick();

    for (int i = 0; i < 24; i++) begin
      int v;
      v = int'($urandom_range(1, 3));
      req0_valid_i = v[0]; req1_valid_i = v[1];
      req0_addr_i = AW'($urandom); req0_wdata_i = DW'($urandom); req0_rw_i = 1'($urandom);
      req1_addr_i = AW'($urandom); req1_wdata_i = DW'($urandom); req1_rw_i = 1'($urandom);
      run_txn(int'($urandom_range(0, 5)), DW'($urandom), 1'($urandom), 1'($urandom));
    end

    // Return arriving on the last permitted wait cycle completes normally.
    req0_valid_i = 1'b1; req1_valid_i = 1'b0; req0_addr_i = 16'h0042; req0_rw_i = 1'b0;
    run_txn(int'(TO), 16'h5A5A, 1'b0, 1'b1);

`ifdef BUS_ARBITER_TIMEOUT_EN
    req0_valid_i = 1'b1; req1_valid_i = 1'b0; req0_addr_i = 16'h0077;
    #1;
    chk("to_ready0", req0_ready_o, 32'd1);
    tick();
    req0_valid_i = 1'b0;
    tick();
    for (int i = 0; i < int'(TO) + 1; i++) begin
      chk_quiet("to_wait");
      chk("to_err", {req0_err_o, req1_err_o}, 32'd0);
      tick();
    end
    exp_rdata[0] = '1;
    chk("to_rvalid0", req0_rvalid_o, 32'd1);
    chk("to_err0", req0_err_o, 32'd1);
    chk("to_rdata0", req0_rdata_o, 32'(exp_rdata[0]));
    chk("to_req1", {req1_rvalid_o, req1_err_o}, 32'd0);
    last_gnt = 0;
    tick();
    chk("to_post", {req0_rvalid_o, req0_err_o}, 32'd0);
    req0_valid_i = 1'b1; req0_addr_i = 16'h0078;
    run_txn(1, 16'h0F0F, 1'b0, 1'b1);
`else
    req0_valid_i = 1'b1; req1_valid_i = 1'b0; req0_addr_i = 16'h0077;
    run_txn(40, 16'hC0DE, 1'b0, 1'b1);
`endif

    // Reset while req1 is waiting: no response, and req0 regains tie priority.
    req0_valid_i = 1'b1; req1_valid_i = 1'b0;
    run_txn(0, DW'($urandom), 1'b0, 1'b0);
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    #1;
    chk("mid_ready1", req1_ready_o, 32'd1);
    tick();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rdata", {req0_rdata_o, req1_rdata_o}, 32'd0);
    chk("mid_rst_bus", {bus_addr_o, bus_wdata_o}, 32'd0);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_gnt = 1;
    bus_valid_i = 1'b1; bus_rdata_i = 16'h7777;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_quiet("late_return");
    end
    bus_valid_i = 1'b0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    run_txn(0, 16'h1357, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
